// File: rtl/shift_pkg.sv
// Shared types for the serial-to-parallel sequencer and the shift register it drives.
package shift_pkg;

  localparam int SHIFT_WIDTH = 8;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    LOAD  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/shift_seq_if.sv
// Bundle between the bit-stream source and shift_seq, plus the command side toward shift_reg.
interface shift_seq_if
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH
);
  localparam int CW = $clog2(WIDTH + 1);

  // bit_valid_i is a one-way strobe with no backpressure: a bit is taken on any
  // edge where the sequencer is shifting, bit_valid_i is high and abort_i is low.
  logic          start_i;
  logic          bit_i;
  logic          bit_valid_i;
  logic          abort_i;
  logic          load_i;
  logic          D_o;
  mode_t         mode_o;
  logic          busy_o;
  logic          done_o;
  logic [CW-1:0] bit_cnt_o;
  seq_state_t    state_dbg;

  modport master (
    output start_i, bit_i, bit_valid_i, abort_i, load_i,
    input  D_o, mode_o, busy_o, done_o, bit_cnt_o, state_dbg
  );

  modport slave (
    input  start_i, bit_i, bit_valid_i, abort_i, load_i,
    output D_o, mode_o, busy_o, done_o, bit_cnt_o, state_dbg
  );

endinterface

// File: rtl/shift_reg.sv
// Downstream WIDTH-bit shift register commanded by shift_seq (hold / load / left / right).
module shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             D,
  input  mode_t            mode_i,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] P
);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      P <= '0;
    end else begin
      case (mode_i)
        LOAD:    P <= pdata;
        LEFT:    P <= {P[WIDTH-2:0], D};
        RIGHT:   P <= {D, P[WIDTH-1:1]};
        default: P <= P;
      endcase
    end
  end

endmodule

// File: rtl/shift_seq.sv
// Frames a strobed serial bit stream into WIDTH shift commands and pulses done_o
// in the cycle the downstream register holds the complete word.
module shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH     = SHIFT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic        clk,
  input logic        nrst,
  shift_seq_if.slave sif
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state;
  logic       load_q;
  mode_t      shift_cmd;

  assign shift_cmd     = MSB_FIRST ? LEFT : RIGHT;
  assign sif.state_dbg = seq_state_t'(state);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= S_IDLE;
      load_q        <= 1'b0;
      sif.D_o       <= 1'b0;
      sif.mode_o    <= HOLD;
      sif.busy_o    <= 1'b0;
      sif.done_o    <= 1'b0;
      sif.bit_cnt_o <= '0;
    end else begin
      // load_q tracks load_i in every state so a level held across a frame never re-fires.
      load_q     <= sif.load_i;
      sif.mode_o <= HOLD;
      sif.done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sif.start_i) begin
            state         <= S_SHIFT;
            sif.busy_o    <= 1'b1;
            sif.bit_cnt_o <= '0;
          end else if (sif.load_i && !load_q) begin
            sif.mode_o <= LOAD;
          end
        end
        S_SHIFT: begin
          if (sif.abort_i) begin
            state      <= S_IDLE;
            sif.busy_o <= 1'b0;
          end else if (sif.bit_valid_i) begin
            sif.D_o       <= sif.bit_i;
            sif.mode_o    <= shift_cmd;
            sif.bit_cnt_o <= sif.bit_cnt_o + CW'(1);
            if (sif.bit_cnt_o == CW'(WIDTH - 1)) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          // The last shift is being applied this cycle; P is complete next cycle.
          state      <= S_DONE;
          sif.done_o <= 1'b1;
        end
        S_DONE: begin
          state      <= S_IDLE;
          sif.busy_o <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          sif.busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench: one MSB-first and one LSB-first sequencer, each feeding a shift_reg.
module tb_shift_seq;
  import shift_pkg::*;

  localparam int W = 8;
  localparam logic [W-1:0] PDATA = 8'h3C;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, bitd = 1'b0, bit_v = 1'b0, abort = 1'b0, load = 1'b0;

  shift_seq_if #(.WIDTH(W)) sif_a ();
  shift_seq_if #(.WIDTH(W)) sif_b ();
  logic [W-1:0] p_a, p_b;

  assign sif_a.start_i = start;  assign sif_b.start_i = start;
  assign sif_a.bit_i = bitd;     assign sif_b.bit_i = bitd;
  assign sif_a.bit_valid_i = bit_v; assign sif_b.bit_valid_i = bit_v;
  assign sif_a.abort_i = abort;  assign sif_b.abort_i = abort;
  assign sif_a.load_i = load;    assign sif_b.load_i = load;

  shift_seq #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .nrst(nrst), .sif(sif_a.slave));
  shift_seq #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .nrst(nrst), .sif(sif_b.slave));
  shift_reg #(.WIDTH(W)) sr_a (.clk(clk), .nrst(nrst), .D(sif_a.D_o), .mode_i(sif_a.mode_o), .pdata(PDATA), .P(p_a));
  shift_reg #(.WIDTH(W)) sr_b (.clk(clk), .nrst(nrst), .D(sif_b.D_o), .mode_i(sif_b.mode_o), .pdata(PDATA), .P(p_b));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: index 0 is MSB-first, index 1 is LSB-first.
  bit         m_recv[2];
  int         m_cnt[2];
  int         m_post[2];
  bit         m_lq[2];
  logic       m_bits[2][W];
  logic       e_d[2];
  logic [1:0] e_mode[2];
  logic       e_busy[2];
  logic       e_done[2];
  int         e_cnt[2];
  logic [W-1:0] exp_qa[$];
  logic [W-1:0] exp_qb[$];

  // Word the register must hold after a full frame: bit j of the stream lands at
  // position W-1-j when sent MSB first, at position j when sent LSB first.
  function automatic logic [W-1:0] frame_word(input int i);
    logic [W-1:0] w;
    w = '0;
    for (int j = 0; j < W; j++)
      if (m_bits[i][j]) w[(i == 0) ? (W - 1 - j) : j] = 1'b1;
    return w;
  endfunction

  always @(posedge clk or negedge nrst) begin
    for (int i = 0; i < 2; i++) begin
      if (!nrst) begin
        m_recv[i] = 0; m_cnt[i] = 0; m_post[i] = 0; m_lq[i] = 0;
        e_d[i] = 0; e_mode[i] = 2'd0; e_busy[i] = 0; e_done[i] = 0; e_cnt[i] = 0;
        if (i == 0) exp_qa.delete(); else exp_qb.delete();
      end else begin
        e_mode[i] = 2'd0;
        e_done[i] = 0;
        if (m_post[i] == 2) begin
          m_post[i] = 1;
          e_done[i] = 1;
        end else if (m_post[i] == 1) begin
          m_post[i] = 0;
        end else if (m_recv[i]) begin
          if (abort) begin
            m_recv[i] = 0;
          end else if (bit_v) begin
            m_bits[i][m_cnt[i]] = bitd;
            e_d[i] = bitd;
            e_mode[i] = (i == 0) ? 2'd2 : 2'd3;
            m_cnt[i]++;
            if (m_cnt[i] == W) begin
              m_recv[i] = 0;
              m_post[i] = 2;
              if (i == 0) exp_qa.push_back(frame_word(0));
              else        exp_qb.push_back(frame_word(1));
            end
          end
        end else if (start) begin
          m_recv[i] = 1;
          m_cnt[i]  = 0;
        end else if (load && !m_lq[i]) begin
          e_mode[i] = 2'd1;
        end
        m_lq[i]   = load;
        e_busy[i] = m_recv[i] || (m_post[i] != 0);
        e_cnt[i]  = m_cnt[i];
      end
    end
  end

  int cnt_done[2], cnt_shift[2], cnt_load[2];

  task automatic clr_counts();
    for (int i = 0; i < 2; i++) begin
      cnt_done[i] = 0; cnt_shift[i] = 0; cnt_load[i] = 0;
    end
  endtask

  task automatic cmp_dut(input int i, input logic d, input logic [1:0] mode, input logic busy,
                         input logic done, input int cnt, input logic [W-1:0] p);
    logic [W-1:0] w;
    string sfx;
    sfx = (i == 0) ? "_a" : "_b";
    chk({"mode", sfx}, int'(mode), int'(e_mode[i]));
    chk({"busy", sfx}, int'(busy), int'(e_busy[i]));
    chk({"done", sfx}, int'(done), int'(e_done[i]));
    chk({"bit_cnt", sfx}, cnt, e_cnt[i]);
    if (e_mode[i] == 2'd2 || e_mode[i] == 2'd3) chk({"d", sfx}, int'(d), int'(e_d[i]));
    if (e_done[i]) begin
      if (i == 0 && exp_qa.size() > 0) begin
        w = exp_qa.pop_front();
        chk({"word", sfx}, int'(p), int'(w));
      end else if (i == 1 && exp_qb.size() > 0) begin
        w = exp_qb.pop_front();
        chk({"word", sfx}, int'(p), int'(w));
      end else begin
        chk({"word_queue", sfx}, 0, 1);
      end
    end
    if (done) cnt_done[i]++;
    if (mode == 2'd2 || mode == 2'd3) cnt_shift[i]++;
    if (mode == 2'd1) cnt_load[i]++;
  endtask

  always @(negedge clk) begin
    cmp_dut(0, sif_a.D_o, sif_a.mode_o, sif_a.busy_o, sif_a.done_o, int'(sif_a.bit_cnt_o), p_a);
    cmp_dut(1, sif_b.D_o, sif_b.mode_o, sif_b.busy_o, sif_b.done_o, int'(sif_b.bit_cnt_o), p_b);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    bit_v = 1'b1; bitd = b;
    tick();
    bit_v = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap);
    for (int j = W - 1; j >= 0; j--) begin
      send_bit(w[j]);
      tick(gap);
    end
  endtask

  task automatic begin_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_both(input string name, input int act_a, input int act_b, input int exp);
    chk({name, "_a"}, act_a, exp);
    chk({name, "_b"}, act_b, exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    tick(2);
    chk_both("rst_busy", int'(sif_a.busy_o), int'(sif_b.busy_o), 0);
    nrst = 1'b1;
    tick();

    // Reset mid-frame after three bits.
    clr_counts();
    begin_frame();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #2 nrst = 1'b0;
    #1;
    chk_both("midrst_mode", int'(sif_a.mode_o), int'(sif_b.mode_o), 0);
    chk_both("midrst_busy", int'(sif_a.busy_o), int'(sif_b.busy_o), 0);
    chk_both("midrst_cnt", int'(sif_a.bit_cnt_o), int'(sif_b.bit_cnt_o), 0);
    chk_both("midrst_d", int'(sif_a.D_o), int'(sif_b.D_o), 0);
    tick(2);
    nrst = 1'b1;
    tick(5);
    chk_both("midrst_nodone", cnt_done[0], cnt_done[1], 0);

    // Load held for three cycles gives one LOAD.
    clr_counts();
    load = 1'b1;
    tick(3);
    load = 1'b0;
    tick(2);
    chk_both("load_once", cnt_load[0], cnt_load[1], 1);
    chk_both("load_p", int'(p_a), int'(p_b), int'(PDATA));

    // Load with start: start wins.
    load = 1'b1; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    chk_both("ldst_busy", int'(sif_a.busy_o), int'(sif_b.busy_o), 1);
    tick();
    chk_both("ldst_noload", cnt_load[0], cnt_load[1], 1);
    abort = 1'b1; tick(); abort = 1'b0;
    tick();

    // Back-to-back frame 1,0,1,0,1,0,1,0.
    clr_counts();
    begin_frame();
    send_word(8'hAA, 0);
    tick(3);
    chk("left_p_a", int'(p_a), 8'hAA);
    chk("right_p_b", int'(p_b), 8'h55);
    chk_both("b2b_done", cnt_done[0], cnt_done[1], 1);
    chk_both("b2b_shifts", cnt_shift[0], cnt_shift[1], 8);
    chk_both("b2b_cnt_held", int'(sif_a.bit_cnt_o), int'(sif_b.bit_cnt_o), 8);

    load = 1'b1; tick(); load = 1'b0; tick(2);
    chk_both("reload_p", int'(p_a), int'(p_b), int'(PDATA));

    // Same bits with two idle cycles between each.
    clr_counts();
    begin_frame();
    send_word(8'hAA, 2);
    tick(3);
    chk("gap_p_a", int'(p_a), 8'hAA);
    chk("gap_p_b", int'(p_b), 8'h55);
    chk_both("gap_done", cnt_done[0], cnt_done[1], 1);

    // Abort together with the fifth bit.
    clr_counts();
    begin_frame();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    bit_v = 1'b1; bitd = 1'b1; abort = 1'b1;
    tick();
    bit_v = 1'b0; abort = 1'b0;
    chk_both("abort_busy", int'(sif_a.busy_o), int'(sif_b.busy_o), 0);
    chk_both("abort_cnt", int'(sif_a.bit_cnt_o), int'(sif_b.bit_cnt_o), 4);
    tick(3);
    chk_both("abort_nodone", cnt_done[0], cnt_done[1], 0);
    chk_both("abort_shifts", cnt_shift[0], cnt_shift[1], 4);

    // Full frame after the abort overwrites the partial word.
    begin_frame();
    send_word(8'hF0, 0);
    tick(3);
    chk("f0_p_a", int'(p_a), 8'hF0);
    chk("f0_p_b", int'(p_b), 8'h0F);

    // bit_valid_i in idle is ignored.
    clr_counts();
    repeat (3) begin
      bit_v = 1'b1; bitd = 1'b1; tick();
      bit_v = 1'b0; tick();
    end
    chk_both("idle_bits", cnt_shift[0] + cnt_load[0], cnt_shift[1] + cnt_load[1], 0);

    // start_i during a frame does not clear the count.
    begin_frame();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    start = 1'b1; tick(); start = 1'b0;
    chk_both("restart_cnt", int'(sif_a.bit_cnt_o), int'(sif_b.bit_cnt_o), 3);
    abort = 1'b1; tick(); abort = 1'b0;
    tick(2);

    chk_both("queue_empty", exp_qa.size(), exp_qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
